// File: rtl/ifid_reg_pkg.sv
// Shared constants for the fetch/decode register and the CP0 exception path:
// ExcCode values, the nop encoding, the default reset PC and the entry state type.
package ifid_reg_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } entry_state_e;

endpackage

// File: rtl/ifid_reg_pc_range_chk.sv
// Combinational legal-fetch check: word aligned and inside [BASE, LIMIT].
// Shared with the data-memory AdEL/AdES logic.
module pc_range_chk #(
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter logic [31:0] LIMIT = 32'h0000_4FFC
) (
  input  logic [31:0] i_addr,
  output logic        o_legal
);

  assign o_legal = (i_addr[1:0] == 2'b00) && (i_addr >= BASE) && (i_addr <= LIMIT);

endmodule

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with stall, flush-to-bubble and PC+8 link value.
// Define IFID_EXC_EN to tag misaligned/out-of-range fetches with AdEL.
//
//  state     | meaning
//  ST_BUBBLE | entry is a nop bubble (reset or flush), Valid_D=0
//  ST_VALID  | entry holds a fetched instruction, Valid_D=1
module ifid_reg
  import ifid_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_4FFC
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC_F,
  input  logic        BD_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        Valid_D,
  output logic        BD_D,
  output logic        Exc_D,
  output logic [4:0]  ExcCode_D
);

  entry_state_e r_state;
  entry_state_e w_state_nxt;

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc8;
  logic        r_bd;
  logic        r_exc;
  logic [4:0]  r_exc_code;

  logic        w_fetch_exc;
  logic [31:0] w_instr_ld;
  logic [31:0] w_pc8_f;

`ifdef IFID_EXC_EN
  logic w_pc_legal;

  pc_range_chk #(
    .BASE  (IM_BASE),
    .LIMIT (IM_LIMIT)
  ) u_pc_range_chk (
    .i_addr  (PC_F),
    .o_legal (w_pc_legal)
  );

  assign w_fetch_exc = ~w_pc_legal;
`else
  assign w_fetch_exc = 1'b0;
`endif

  // A faulting fetch must not reach decode as a real instruction.
  assign w_instr_ld = w_fetch_exc ? NOP_INSTR : Instr_F;
  assign w_pc8_f    = PC_F + 32'd8;

  always_comb begin
    w_state_nxt = r_state;
    if (Flush)
      w_state_nxt = ST_BUBBLE;
    else if (!Stall)
      w_state_nxt = ST_VALID;
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      r_state <= ST_BUBBLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= RESET_PC;
      r_pc8      <= RESET_PC + 32'd8;
      r_bd       <= 1'b0;
      r_exc      <= 1'b0;
      r_exc_code <= EXC_INT;
    end else if (Flush) begin
      // Bubble keeps the fetch PC so a later exception reports a sane EPC.
      r_instr    <= NOP_INSTR;
      r_pc       <= PC_F;
      r_pc8      <= w_pc8_f;
      r_bd       <= 1'b0;
      r_exc      <= 1'b0;
      r_exc_code <= EXC_INT;
    end else if (!Stall) begin
      r_instr    <= w_instr_ld;
      r_pc       <= PC_F;
      r_pc8      <= w_pc8_f;
      r_bd       <= BD_F;
      r_exc      <= w_fetch_exc;
      r_exc_code <= w_fetch_exc ? EXC_ADEL : EXC_INT;
    end
  end

  assign Instr_D   = r_instr;
  assign PC_D      = r_pc;
  assign PC8_D     = r_pc8;
  assign Valid_D   = (r_state == ST_VALID);
  assign BD_D      = r_bd;
  assign Exc_D     = r_exc;
  assign ExcCode_D = r_exc_code;

endmodule

// File: tb/tb_ifid_reg.sv
// Self-checking bench for ifid_reg: directed scenarios plus randomized traffic
// against a behavioural model of the entry; follows IFID_EXC_EN if defined.
module tb_ifid_reg;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush, BD_F;
  logic [31:0] Instr_F, PC_F;
  logic [31:0] Instr_D, PC_D, PC8_D;
  logic        Valid_D, BD_D, Exc_D;
  logic [4:0]  ExcCode_D;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IFID_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  // Behavioural model of what decode should see.
  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_bd, m_exc;
  logic [4:0]  m_code;

  ifid_reg dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Stall     (Stall),
    .Flush     (Flush),
    .Instr_F   (Instr_F),
    .PC_F      (PC_F),
    .BD_F      (BD_F),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PC8_D     (PC8_D),
    .Valid_D   (Valid_D),
    .BD_D      (BD_D),
    .Exc_D     (Exc_D),
    .ExcCode_D (ExcCode_D)
  );

  always #5 Clk = ~Clk;

  function automatic bit fetch_ok(input logic [31:0] pc);
    return (pc % 4 == 0) && (pc >= 32'h3000) && (pc <= 32'h4FFC);
  endfunction

  task automatic model_edge();
    if (Rst) begin
      m_instr = 0; m_pc = 32'h3000; m_valid = 0; m_bd = 0; m_exc = 0; m_code = 0;
    end else if (Flush) begin
      m_instr = 0; m_pc = PC_F; m_valid = 0; m_bd = 0; m_exc = 0; m_code = 0;
    end else if (!Stall) begin
      m_pc    = PC_F;
      m_valid = 1;
      m_bd    = BD_F;
      m_exc   = EXC_ON && !fetch_ok(PC_F);
      m_code  = m_exc ? 5'd4 : 5'd0;
      m_instr = m_exc ? 32'h0 : Instr_F;
    end
  endtask

  task automatic cyc(input logic rst, input logic flush, input logic stall,
                     input logic [31:0] pc, input logic [31:0] instr, input logic bd);
    Rst = rst; Flush = flush; Stall = stall; PC_F = pc; Instr_F = instr; BD_F = bd;
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 32'h1234_5678, 32'hDEAD_BEEF, 1);
    cyc(1, 0, 1, 32'h1234_5678, 32'hDEAD_BEEF, 1);
    n_checks++;
    if ({PC_D, PC8_D, Instr_D, Valid_D, BD_D, Exc_D, ExcCode_D} !==
        {32'h3000, 32'h3008, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h pc8=%h instr=%h v=%b bd=%b exc=%b code=%0d",
               PC_D, PC8_D, Instr_D, Valid_D, BD_D, Exc_D, ExcCode_D);
    end
    cyc(0, 0, 0, 32'h3000, 32'h3C01_1234, 0);
    n_checks++;
    if ({Instr_D, PC_D, Valid_D} !== {32'h3C01_1234, 32'h3000, 1'b1}) begin
      n_fail++;
      $display("FAIL first_load: got instr=%h pc=%h v=%b want 3c011234 00003000 1",
               Instr_D, PC_D, Valid_D);
    end
  endtask

  task automatic test_stall();
    cyc(0, 0, 0, 32'h3004, 32'h2001_0005, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 32'h3008 + 4 * i, $urandom, 1);
      n_checks++;
      if ({PC_D, PC8_D, Instr_D, Valid_D, BD_D} !== {32'h3004, 32'h300C, 32'h2001_0005, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got pc=%h pc8=%h instr=%h v=%b bd=%b want 3004 300c 20010005 1 0",
                 i, PC_D, PC8_D, Instr_D, Valid_D, BD_D);
      end
    end
    // Rst during a stall still loads reset values.
    cyc(1, 0, 1, 32'h3020, 32'h1111_1111, 0);
    n_checks++;
    if ({PC_D, Valid_D} !== {32'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_stall: got pc=%h v=%b want 3000 0", PC_D, Valid_D);
    end
  endtask

  task automatic test_flush();
    cyc(0, 0, 0, 32'h300C, 32'h0000_0020, 1);
    cyc(0, 1, 1, 32'h3010, 32'hFFFF_FFFF, 1);
    n_checks++;
    if ({Instr_D, Valid_D, BD_D, PC_D, PC8_D, Exc_D} !== {32'h0, 1'b0, 1'b0, 32'h3010, 32'h3018, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_over_stall: got instr=%h v=%b bd=%b pc=%h pc8=%h exc=%b",
               Instr_D, Valid_D, BD_D, PC_D, PC8_D, Exc_D);
    end
    cyc(0, 0, 0, 32'h3010, 32'hAC22_0000, 0);
    n_checks++;
    if ({Instr_D, Valid_D, PC_D} !== {32'hAC22_0000, 1'b1, 32'h3010}) begin
      n_fail++;
      $display("FAIL refetch_after_flush: got instr=%h v=%b pc=%h", Instr_D, Valid_D, PC_D);
    end
  endtask

  task automatic test_bd_wrap();
    cyc(0, 0, 0, 32'h3014, 32'h0000_0000, 1);
    n_checks++;
    if ({BD_D, PC8_D} !== {1'b1, 32'h301C}) begin
      n_fail++;
      $display("FAIL bd_slot: got bd=%b pc8=%h want 1 0000301c", BD_D, PC8_D);
    end
    cyc(0, 0, 0, 32'hFFFF_FFFC, 32'h1234_0000, 0);
    n_checks++;
    if ({PC_D, PC8_D, Valid_D, Exc_D} !== {32'hFFFF_FFFC, 32'h0000_0004, 1'b1, EXC_ON}) begin
      n_fail++;
      $display("FAIL pc8_wrap: got pc=%h pc8=%h v=%b exc=%b want fffffffc 00000004 1 %b",
               PC_D, PC8_D, Valid_D, Exc_D, EXC_ON);
    end
  endtask

  task automatic test_exc();
    logic [31:0] pcs [5] = '{32'h3002, 32'h5000, 32'h4FFC, 32'h3000, 32'h2FFC};
    bit          bad [5] = '{1, 1, 0, 0, 1};
    logic [31:0] instr;
    for (int i = 0; i < 5; i++) begin
      instr = 32'h8C00_0000 | i;
      cyc(0, 0, 0, pcs[i], instr, 0);
      n_checks++;
      if (EXC_ON && bad[i]) begin
        if ({Exc_D, ExcCode_D, Instr_D, Valid_D} !== {1'b1, 5'd4, 32'h0, 1'b1}) begin
          n_fail++;
          $display("FAIL adel[%h]: got exc=%b code=%0d instr=%h v=%b want 1 4 0 1",
                   pcs[i], Exc_D, ExcCode_D, Instr_D, Valid_D);
        end
      end else begin
        if ({Exc_D, ExcCode_D, Instr_D, Valid_D} !== {1'b0, 5'd0, instr, 1'b1}) begin
          n_fail++;
          $display("FAIL no_adel[%h]: got exc=%b code=%0d instr=%h v=%b want 0 0 %h 1",
                   pcs[i], Exc_D, ExcCode_D, Instr_D, Valid_D, instr);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int i = 0; i < 400; i++) begin
      pc = $urandom_range(32'h5040, 32'h2FC0);
      if ($urandom_range(3, 0) != 0) pc[1:0] = 2'b00;
      cyc(($urandom_range(31, 0) == 0), ($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0),
          pc, $urandom, 1'($urandom));
      n_checks++;
      if ({Instr_D, PC_D, PC8_D, Valid_D, BD_D, Exc_D, ExcCode_D} !==
          {m_instr, m_pc, m_pc + 32'd8, m_valid, m_bd, m_exc, m_code}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h %h %h %b %b %b %0d want %h %h %h %b %b %b %0d", i,
                 Instr_D, PC_D, PC8_D, Valid_D, BD_D, Exc_D, ExcCode_D,
                 m_instr, m_pc, m_pc + 32'd8, m_valid, m_bd, m_exc, m_code);
      end
    end
  endtask

  initial begin
    Rst = 1; Stall = 0; Flush = 0; BD_F = 0; Instr_F = 0; PC_F = 32'h3000;
    test_reset();
    test_stall();
    test_flush();
    test_bd_wrap();
    test_exc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
